// File: rtl/instr_fetch_decoder.sv
// Instruction fetch sequencer and field decoder: reads the 64-entry instruction
// store and hands each decoded word to the execute stage over valid/ready.
module instr_fetch_decoder #(
    parameter logic [5:0] START_PC = 6'd0,
    parameter logic [5:0] LAST_PC  = 6'd63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_rd,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [5:0]  dec_opcode,
    output logic [2:0]  dec_fmt,
    output logic [4:0]  dec_rdst2,
    output logic [4:0]  dec_rdst1,
    output logic [4:0]  dec_rsrc2,
    output logic [4:0]  dec_rsrc1,
    output logic [15:0] dec_imm16,
    output logic [7:0]  dec_maddr,
    output logic [5:0]  pc,
    output logic        illegal,
    output logic        halted
);

    localparam logic [2:0] FMT_IMM   = 3'd0;
    localparam logic [2:0] FMT_MOV   = 3'd1;
    localparam logic [2:0] FMT_LOAD  = 3'd2;
    localparam logic [2:0] FMT_STORE = 3'd3;
    localparam logic [2:0] FMT_ALU   = 3'd4;

    localparam logic [5:0] OP_IMM      = 6'b000000;
    localparam logic [5:0] OP_MOV      = 6'b000001;
    localparam logic [5:0] OP_LOAD     = 6'b000010;
    localparam logic [5:0] OP_STORE    = 6'b000011;
    localparam logic [5:0] OP_ALU_LAST = 6'b010000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        OUT,
        HALT
    } state_t;

    typedef struct packed {
        logic        legal;
        logic [5:0]  opcode;
        logic [2:0]  fmt;
        logic [4:0]  rdst2;
        logic [4:0]  rdst1;
        logic [4:0]  rsrc2;
        logic [4:0]  rsrc1;
        logic [15:0] imm16;
        logic [7:0]  maddr;
    } fields_t;

    state_t  state;
    state_t  state_nx;
    fields_t cap_p0;

    // Fields a format does not use are forced to zero; an illegal opcode
    // yields an all-zero record with legal cleared.
    function automatic fields_t decode_word(input logic [31:0] w);
        fields_t f;
        f        = '0;
        f.legal  = 1'b1;
        f.opcode = w[31:26];
        case (w[31:26])
            OP_IMM: begin
                f.fmt   = FMT_IMM;
                f.rdst2 = w[25:21];
                f.imm16 = w[15:0];
            end
            OP_MOV: begin
                f.fmt   = FMT_MOV;
                f.rdst2 = w[25:21];
                f.rsrc1 = w[4:0];
            end
            OP_LOAD: begin
                f.fmt   = FMT_LOAD;
                f.rdst2 = w[25:21];
                f.maddr = w[7:0];
            end
            OP_STORE: begin
                f.fmt   = FMT_STORE;
                f.maddr = w[25:18];
                f.rsrc1 = w[4:0];
            end
            default: begin
                if (w[31:26] <= OP_ALU_LAST) begin
                    f.fmt   = FMT_ALU;
                    f.rdst2 = w[25:21];
                    f.rdst1 = w[20:16];
                    f.rsrc2 = w[9:5];
                    f.rsrc1 = w[4:0];
                end else begin
                    f = '0;
                end
            end
        endcase
        return f;
    endfunction

    assign cap_p0 = decode_word(imem_rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Read strobe and address are decoded from state so reset drops them at once.
    always_comb begin
        state_nx  = state;
        imem_rd   = 1'b0;
        imem_addr = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                imem_rd   = 1'b1;
                imem_addr = pc;
                state_nx  = CAP;
            end
            CAP: begin
                state_nx = cap_p0.legal ? OUT : HALT;
            end
            OUT: begin
                if (dec_ready) begin
                    state_nx = (pc == LAST_PC) ? HALT : REQ;
                end
            end
            HALT: begin
                if (start) begin
                    state_nx = REQ;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Capture stage: read data is valid in CAP, one cycle after the REQ strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= START_PC;
            dec_valid  <= 1'b0;
            dec_opcode <= '0;
            dec_fmt    <= '0;
            dec_rdst2  <= '0;
            dec_rdst1  <= '0;
            dec_rsrc2  <= '0;
            dec_rsrc1  <= '0;
            dec_imm16  <= '0;
            dec_maddr  <= '0;
            illegal    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc <= START_PC;
                    end
                end
                CAP: begin
                    dec_opcode <= cap_p0.opcode;
                    dec_fmt    <= cap_p0.fmt;
                    dec_rdst2  <= cap_p0.rdst2;
                    dec_rdst1  <= cap_p0.rdst1;
                    dec_rsrc2  <= cap_p0.rsrc2;
                    dec_rsrc1  <= cap_p0.rsrc1;
                    dec_imm16  <= cap_p0.imm16;
                    dec_maddr  <= cap_p0.maddr;
                    dec_valid  <= cap_p0.legal;
                    if (!cap_p0.legal) begin
                        illegal <= 1'b1;
                        halted  <= 1'b1;
                    end
                end
                OUT: begin
                    if (dec_valid && dec_ready) begin
                        dec_valid <= 1'b0;
                        if (pc == LAST_PC) begin
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 6'd1;
                        end
                    end
                end
                HALT: begin
                    if (start) begin
                        illegal <= 1'b0;
                        halted  <= 1'b0;
                        pc      <= START_PC;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decoder.sv
// Scoreboard bench for instr_fetch_decoder: three instances cover the default
// program range, a short LAST_PC and a start at the top of the store.
module tb_instr_fetch_decoder;

    localparam logic [31:0] W_ILL    = 32'h4400_0000;
    localparam logic [31:0] W_POISON = 32'hFFFF_FFFF;
    localparam logic [31:0] W_ADD    = 32'h1064_0041;
    localparam logic [31:0] W_IMM    = 32'h00A0_BEEF;
    localparam logic [31:0] W_STORE  = 32'h0E94_0007;
    localparam logic [31:0] W_MOV    = 32'h04E0_FFFF;
    localparam logic [31:0] W_LOAD   = 32'h093F_0F3C;
    localparam logic [31:0] W_OP16   = 32'h4022_0064;

    typedef struct packed {
        logic [5:0]  pc;
        logic [5:0]  op;
        logic [2:0]  fmt;
        logic [4:0]  rd2;
        logic [4:0]  rd1;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [15:0] imm;
        logic [7:0]  maddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic start_a, ready_a, rd_a, valid_a, ill_a, halt_a;
    logic [5:0] addr_a, op_a, pc_a;
    logic [31:0] rdata_a;
    logic [2:0] fmt_a;
    logic [4:0] rd2_a, rd1_a, rs2_a, rs1_a;
    logic [15:0] imm_a;
    logic [7:0] maddr_a;

    logic start_b, ready_b, rd_b, valid_b, ill_b, halt_b;
    logic [5:0] addr_b, op_b, pc_b;
    logic [31:0] rdata_b;
    logic [2:0] fmt_b;
    logic [4:0] rd2_b, rd1_b, rs2_b, rs1_b;
    logic [15:0] imm_b;
    logic [7:0] maddr_b;

    logic start_c, ready_c, rd_c, valid_c, ill_c, halt_c;
    logic [5:0] addr_c, op_c, pc_c;
    logic [31:0] rdata_c;
    logic [2:0] fmt_c;
    logic [4:0] rd2_c, rd1_c, rs2_c, rs1_c;
    logic [15:0] imm_c;
    logic [7:0] maddr_c;

    int tests = 0;
    int fails = 0;
    exp_t expq[$];
    exp_t expq_b[$];
    exp_t expq_c[$];
    logic [31:0] mem [64];

    bit mon_on = 1'b0;
    int rdcnt_b = 0;
    int rdcnt_c = 0;
    bit rd_b_past = 1'b0;
    bit rd_c_other = 1'b0;

    instr_fetch_decoder dut_a (
        .clk(clk), .rst(rst), .start(start_a), .imem_rd(rd_a), .imem_addr(addr_a),
        .imem_rdata(rdata_a), .dec_valid(valid_a), .dec_ready(ready_a),
        .dec_opcode(op_a), .dec_fmt(fmt_a), .dec_rdst2(rd2_a), .dec_rdst1(rd1_a),
        .dec_rsrc2(rs2_a), .dec_rsrc1(rs1_a), .dec_imm16(imm_a), .dec_maddr(maddr_a),
        .pc(pc_a), .illegal(ill_a), .halted(halt_a)
    );

    instr_fetch_decoder #(.START_PC(6'd0), .LAST_PC(6'd2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .imem_rd(rd_b), .imem_addr(addr_b),
        .imem_rdata(rdata_b), .dec_valid(valid_b), .dec_ready(ready_b),
        .dec_opcode(op_b), .dec_fmt(fmt_b), .dec_rdst2(rd2_b), .dec_rdst1(rd1_b),
        .dec_rsrc2(rs2_b), .dec_rsrc1(rs1_b), .dec_imm16(imm_b), .dec_maddr(maddr_b),
        .pc(pc_b), .illegal(ill_b), .halted(halt_b)
    );

    instr_fetch_decoder #(.START_PC(6'd63), .LAST_PC(6'd63)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .imem_rd(rd_c), .imem_addr(addr_c),
        .imem_rdata(rdata_c), .dec_valid(valid_c), .dec_ready(ready_c),
        .dec_opcode(op_c), .dec_fmt(fmt_c), .dec_rdst2(rd2_c), .dec_rdst1(rd1_c),
        .dec_rsrc2(rs2_c), .dec_rsrc1(rs1_c), .dec_imm16(imm_c), .dec_maddr(maddr_c),
        .pc(pc_c), .illegal(ill_c), .halted(halt_c)
    );

    always #5 clk = ~clk;

    // Instruction store: data one cycle after the strobe, poison otherwise.
    always @(posedge clk) begin
        rdata_a <= rd_a ? mem[addr_a] : W_POISON;
        rdata_b <= rd_b ? mem[addr_b] : W_POISON;
        rdata_c <= rd_c ? mem[addr_c] : W_POISON;
        if (mon_on && rd_b) begin
            rdcnt_b <= rdcnt_b + 1;
            if (addr_b > 6'd2) rd_b_past <= 1'b1;
        end
        if (mon_on && rd_c) begin
            rdcnt_c <= rdcnt_c + 1;
            if (addr_c != 6'd63) rd_c_other <= 1'b1;
        end
    end

    function automatic exp_t mk(input logic [5:0] p, input logic [5:0] op, input logic [2:0] f,
                                input logic [4:0] d2, input logic [4:0] d1, input logic [4:0] s2,
                                input logic [4:0] s1, input logic [15:0] im, input logic [7:0] ma);
        mk = {p, op, f, d2, d1, s2, s1, im, ma};
    endfunction

    function automatic exp_t obs_a();
        return {pc_a, op_a, fmt_a, rd2_a, rd1_a, rs2_a, rs1_a, imm_a, maddr_a};
    endfunction

    function automatic exp_t obs_b();
        return {pc_b, op_b, fmt_b, rd2_b, rd1_b, rs2_b, rs1_b, imm_b, maddr_b};
    endfunction

    function automatic exp_t obs_c();
        return {pc_c, op_c, fmt_c, rd2_c, rd1_c, rs2_c, rs1_c, imm_c, maddr_c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_a(input int budget, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!valid_a && cycles < budget);
        tests++;
        if (valid_a !== 1'b1) begin
            fails++;
            $display("FAIL valid_timeout dec_valid=%b after %0d cycles, required 1", valid_a, cycles);
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++;
        if ({valid_a, rd_a, addr_a, ill_a, halt_a} !== 10'd0) begin
            fails++;
            $display("FAIL reset_ctrl got valid/rd/addr/ill/halt=%b required all 0",
                     {valid_a, rd_a, addr_a, ill_a, halt_a});
        end
        tests++;
        if (obs_a() !== mk(6'd0, 6'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 8'd0)) begin
            fails++;
            $display("FAIL reset_fields got=%h required=0", obs_a());
        end
        tests++;
        if (pc_c !== 6'd63 || pc_b !== 6'd0) begin
            fails++;
            $display("FAIL reset_start_pc got pc_b=%0d pc_c=%0d required 0 and 63", pc_b, pc_c);
        end
        step();
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (3) step();
        tests++;
        if (rd_a !== 1'b0 || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold got rd=%b valid=%b required 0 0", rd_a, valid_a);
        end
    endtask

    task automatic test_add();
        int cyc;
        exp_t e;
        mem[0] = W_ADD;
        expq.push_back(mk(6'd0, 6'h04, 3'd4, 5'd3, 5'd4, 5'd2, 5'd1, 16'd0, 8'd0));
        ready_a = 1'b1;
        pulse_start_a();
        tests++;
        if (rd_a !== 1'b1 || addr_a !== 6'd0) begin
            fails++;
            $display("FAIL add_req got rd=%b addr=%0d required 1 0", rd_a, addr_a);
        end
        wait_valid_a(10, cyc);
        tests++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL add_latency got %0d cycles required 2", cyc);
        end
        e = expq.pop_front();
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL add_fields got=%h required=%h", obs_a(), e);
        end
        step();
        tests++;
        if (rd_a !== 1'b1 || addr_a !== 6'd1 || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL add_next_req got rd=%b addr=%0d valid=%b required 1 1 0", rd_a, addr_a, valid_a);
        end
        repeat (3) step();
        tests++;
        if (halt_a !== 1'b1 || ill_a !== 1'b1) begin
            fails++;
            $display("FAIL add_then_illegal got halted=%b illegal=%b required 1 1", halt_a, ill_a);
        end
    endtask

    task automatic test_imm_store();
        int cyc;
        exp_t e;
        mem[0] = W_IMM;
        mem[1] = W_STORE;
        mem[2] = W_ILL;
        expq.push_back(mk(6'd0, 6'h00, 3'd0, 5'd5, 5'd0, 5'd0, 5'd0, 16'hBEEF, 8'd0));
        expq.push_back(mk(6'd1, 6'h03, 3'd3, 5'd0, 5'd0, 5'd0, 5'd7, 16'd0, 8'hA5));
        ready_a = 1'b1;
        pulse_start_a();
        tests++;
        if (ill_a !== 1'b0 || halt_a !== 1'b0) begin
            fails++;
            $display("FAIL restart_clears got illegal=%b halted=%b required 0 0", ill_a, halt_a);
        end
        wait_valid_a(10, cyc);
        e = expq.pop_front();
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL imm_fields got=%h required=%h", obs_a(), e);
        end
        wait_valid_a(10, cyc);
        tests++;
        if (cyc !== 3) begin
            fails++;
            $display("FAIL b2b_spacing got %0d cycles required 3", cyc);
        end
        e = expq.pop_front();
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL store_fields got=%h required=%h", obs_a(), e);
        end
        repeat (4) step();
    endtask

    task automatic test_backpressure();
        int cyc;
        exp_t e;
        mem[0] = W_ADD;
        mem[1] = W_MOV;
        mem[2] = W_LOAD;
        mem[3] = W_ILL;
        expq.push_back(mk(6'd0, 6'h04, 3'd4, 5'd3, 5'd4, 5'd2, 5'd1, 16'd0, 8'd0));
        expq.push_back(mk(6'd1, 6'h01, 3'd1, 5'd7, 5'd0, 5'd0, 5'd31, 16'd0, 8'd0));
        expq.push_back(mk(6'd2, 6'h02, 3'd2, 5'd9, 5'd0, 5'd0, 5'd0, 16'd0, 8'h3C));
        ready_a = 1'b0;
        pulse_start_a();
        wait_valid_a(10, cyc);
        e = expq.pop_front();
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL bp_add_fields got=%h required=%h", obs_a(), e);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (valid_a !== 1'b1 || rd_a !== 1'b0 || obs_a() !== e) begin
                fails++;
                $display("FAIL bp_hold cycle %0d got valid=%b rd=%b fields=%h required 1 0 %h",
                         i, valid_a, rd_a, obs_a(), e);
            end
        end
        ready_a = 1'b1;
        step();
        tests++;
        if (rd_a !== 1'b1 || addr_a !== 6'd1 || pc_a !== 6'd1 || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept_req got rd=%b addr=%0d pc=%0d valid=%b required 1 1 1 0",
                     rd_a, addr_a, pc_a, valid_a);
        end
        wait_valid_a(10, cyc);
        e = expq.pop_front();
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL mov_fields got=%h required=%h", obs_a(), e);
        end
        wait_valid_a(10, cyc);
        e = expq.pop_front();
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL load_fields got=%h required=%h", obs_a(), e);
        end
        repeat (4) step();
    endtask

    task automatic test_illegal();
        int cyc;
        bit saw;
        exp_t e;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem[0] = W_ILL;
        ready_a = 1'b1;
        pulse_start_a();
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            saw |= valid_a;
        end
        tests++;
        if (saw || ill_a !== 1'b1 || halt_a !== 1'b1) begin
            fails++;
            $display("FAIL illegal_flags got saw_valid=%b illegal=%b halted=%b required 0 1 1", saw, ill_a, halt_a);
        end
        tests++;
        if (obs_a() !== mk(6'd0, 6'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 8'd0)) begin
            fails++;
            $display("FAIL illegal_fields got=%h required=0", obs_a());
        end
        mem[0] = W_OP16;
        mem[1] = W_ILL;
        expq.push_back(mk(6'd0, 6'h10, 3'd4, 5'd1, 5'd2, 5'd3, 5'd4, 16'd0, 8'd0));
        pulse_start_a();
        tests++;
        if (ill_a !== 1'b0 || halt_a !== 1'b0 || rd_a !== 1'b1 || addr_a !== 6'd0) begin
            fails++;
            $display("FAIL illegal_restart got illegal=%b halted=%b rd=%b addr=%0d required 0 0 1 0",
                     ill_a, halt_a, rd_a, addr_a);
        end
        wait_valid_a(10, cyc);
        e = expq.pop_front();
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL op16_fields got=%h required=%h", obs_a(), e);
        end
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            saw |= valid_a;
        end
        tests++;
        if (saw || ill_a !== 1'b1 || halt_a !== 1'b1 || pc_a !== 6'd1) begin
            fails++;
            $display("FAIL op17_halts got saw_valid=%b illegal=%b halted=%b pc=%0d required 0 1 1 1",
                     saw, ill_a, halt_a, pc_a);
        end
    endtask

    task automatic test_last_pc();
        int base;
        int accepts;
        exp_t e;
        mem[0] = W_ADD;
        mem[1] = W_IMM;
        mem[2] = W_STORE;
        mem[3] = W_ADD;
        expq_b.push_back(mk(6'd0, 6'h04, 3'd4, 5'd3, 5'd4, 5'd2, 5'd1, 16'd0, 8'd0));
        expq_b.push_back(mk(6'd1, 6'h00, 3'd0, 5'd5, 5'd0, 5'd0, 5'd0, 16'hBEEF, 8'd0));
        expq_b.push_back(mk(6'd2, 6'h03, 3'd3, 5'd0, 5'd0, 5'd0, 5'd7, 16'd0, 8'hA5));
        base = rdcnt_b;
        accepts = 0;
        ready_b = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (valid_b) begin
                accepts++;
                e = (expq_b.size() > 0) ? expq_b.pop_front() : '0;
                tests++;
                if (obs_b() !== e) begin
                    fails++;
                    $display("FAIL lastpc_fields got=%h required=%h", obs_b(), e);
                end
            end
        end
        tests++;
        if (accepts !== 3 || halt_b !== 1'b1 || ill_b !== 1'b0) begin
            fails++;
            $display("FAIL lastpc_halt got accepts=%0d halted=%b illegal=%b required 3 1 0", accepts, halt_b, ill_b);
        end
        tests++;
        if (rdcnt_b - base !== 3 || rd_b_past) begin
            fails++;
            $display("FAIL lastpc_reads got reads=%0d past_last=%b required 3 0", rdcnt_b - base, rd_b_past);
        end
    endtask

    task automatic test_start63();
        int base;
        int accepts;
        exp_t e;
        mem[63] = W_IMM;
        mem[0] = W_ADD;
        expq_c.push_back(mk(6'd63, 6'h00, 3'd0, 5'd5, 5'd0, 5'd0, 5'd0, 16'hBEEF, 8'd0));
        base = rdcnt_c;
        accepts = 0;
        ready_c = 1'b1;
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_c) begin
                accepts++;
                e = (expq_c.size() > 0) ? expq_c.pop_front() : '0;
                tests++;
                if (obs_c() !== e) begin
                    fails++;
                    $display("FAIL top_fields got=%h required=%h", obs_c(), e);
                end
            end
        end
        tests++;
        if (accepts !== 1 || halt_c !== 1'b1 || ill_c !== 1'b0 || rdcnt_c - base !== 1 || rd_c_other
            || rd_c !== 1'b0 || addr_c !== 6'd0) begin
            fails++;
            $display("FAIL top_halt got accepts=%0d halted=%b illegal=%b reads=%0d other_addr=%b required 1 1 0 1 0",
                     accepts, halt_c, ill_c, rdcnt_c - base, rd_c_other);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        bit saw;
        exp_t e;
        mem[0] = W_ADD;
        mem[1] = W_IMM;
        mem[2] = W_ILL;
        expq.push_back(mk(6'd0, 6'h04, 3'd4, 5'd3, 5'd4, 5'd2, 5'd1, 16'd0, 8'd0));
        expq.push_back(mk(6'd1, 6'h00, 3'd0, 5'd5, 5'd0, 5'd0, 5'd0, 16'hBEEF, 8'd0));
        ready_a = 1'b1;
        pulse_start_a();
        wait_valid_a(10, cyc);
        e = expq.pop_front();
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL rst_pre0_fields got=%h required=%h", obs_a(), e);
        end
        wait_valid_a(10, cyc);
        e = expq.pop_front();
        ready_a = 1'b0;
        tests++;
        if (obs_a() !== e) begin
            fails++;
            $display("FAIL rst_pre1_fields got=%h required=%h", obs_a(), e);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (valid_a !== 1'b0 || rd_a !== 1'b0
            || obs_a() !== mk(6'd0, 6'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 8'd0)) begin
            fails++;
            $display("FAIL rst_out got valid=%b rd=%b fields=%h required 0 0 0", valid_a, rd_a, obs_a());
        end
        step();
        rst = 1'b0;
        ready_a = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            saw |= valid_a | rd_a;
        end
        tests++;
        if (saw) begin
            fails++;
            $display("FAIL rst_idle got activity=%b required 0", saw);
        end
        pulse_start_a();
        #2 rst = 1'b1;
        #1;
        tests++;
        if (rd_a !== 1'b0 || addr_a !== 6'd0) begin
            fails++;
            $display("FAIL rst_req_drop got rd=%b addr=%0d required 0 0", rd_a, addr_a);
        end
        step();
        rst = 1'b0;
        pulse_start_a();
        step();
        #2 rst = 1'b1;
        #1;
        tests++;
        if (valid_a !== 1'b0 || rd_a !== 1'b0 || pc_a !== 6'd0) begin
            fails++;
            $display("FAIL rst_cap got valid=%b rd=%b pc=%0d required 0 0 0", valid_a, rd_a, pc_a);
        end
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            saw |= valid_a | rd_a;
        end
        tests++;
        if (saw || ill_a !== 1'b0 || halt_a !== 1'b0) begin
            fails++;
            $display("FAIL rst_cap_discard got activity=%b illegal=%b halted=%b required 0 0 0", saw, ill_a, halt_a);
        end
    endtask

    initial begin
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        ready_c = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = W_ILL;
        step();
        step();
        test_reset();
        test_add();
        test_imm_store();
        test_backpressure();
        test_illegal();
        test_last_pc();
        test_start63();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete, required completion before 100000");
        $fatal(1);
    end

endmodule
